ll_event_detector: RTL and testbench

- Consumes the windowed line-length stream produced by the line-length datapath: signed sum plus its data_valid strobe.
- Decides seizure onset and offset using a dual-threshold hysteresis FSM with consecutive-window qualification and a post-event hold-off.
- Outputs an alarm level, an onset strobe, the peak line-length of each event, and a saturating event counter for the controller.

---
 rtl/ll_event_detector.sv | 180 ++++++++++++++++++
 tb/tb_ll_event_detector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ll_event_detector.sv
// ============================================================================
// Module  : ll_event_detector
// Brief   : Hysteresis onset/offset detector over the windowed line-length stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ll_event_detector #(
    parameter int DATA_WIDTH = 25,
    parameter int CNT_WIDTH  = 8,
    parameter int HOLD_WIDTH = 10,
    parameter int EVT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] thr_hi,
    input  logic [DATA_WIDTH-1:0] thr_lo,
    input  logic [CNT_WIDTH-1:0]  n_onset,
    input  logic [CNT_WIDTH-1:0]  n_offset,
    input  logic [HOLD_WIDTH-1:0] n_hold,
    output logic                  alarm,
    output logic                  onset_pulse,
    output logic [DATA_WIDTH-1:0] peak,
    output logic                  peak_valid,
    output logic [EVT_WIDTH-1:0]  event_count,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CAND  = 2'd1,
        S_ALARM = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [HOLD_WIDTH-1:0] r_hcnt;
    logic [DATA_WIDTH-1:0] r_peak_run;
    logic [DATA_WIDTH-1:0] r_peak;
    logic                  r_onset;
    logic                  r_pv;
    logic [EVT_WIDTH-1:0]  r_evt;

    state_t                w_nxt_state;
    logic [CNT_WIDTH-1:0]  w_nxt_cnt;
    logic [HOLD_WIDTH-1:0] w_nxt_hcnt;
    logic [DATA_WIDTH-1:0] w_nxt_peak_run;
    logic [DATA_WIDTH-1:0] w_nxt_peak;
    logic                  w_nxt_onset;
    logic                  w_nxt_pv;
    logic [EVT_WIDTH-1:0]  w_nxt_evt;
    logic                  w_enter_alarm;

    logic                  w_proc;
    logic                  w_above;
    logic                  w_below;
    logic [CNT_WIDTH:0]    w_cnt_inc;
    logic [CNT_WIDTH:0]    w_on_eff;
    logic [CNT_WIDTH:0]    w_off_eff;
    logic [HOLD_WIDTH:0]   w_hcnt_inc;
    logic [DATA_WIDTH-1:0] w_peak_max;

    assign w_proc     = !en && din_valid;
    assign w_above    = $signed(din) > $signed(thr_hi);
    assign w_below    = $signed(din) < $signed(thr_lo);
    // Counters are compared one bit wider so cnt+1 can never wrap before the compare.
    assign w_cnt_inc  = {1'b0, r_cnt} + 1'b1;
    assign w_hcnt_inc = {1'b0, r_hcnt} + 1'b1;
    assign w_on_eff   = (n_onset == '0)  ? {{CNT_WIDTH{1'b0}}, 1'b1} : {1'b0, n_onset};
    assign w_off_eff  = (n_offset == '0) ? {{CNT_WIDTH{1'b0}}, 1'b1} : {1'b0, n_offset};
    assign w_peak_max = ($signed(din) > $signed(r_peak_run)) ? din : r_peak_run;

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_nxt_hcnt     = r_hcnt;
        w_nxt_peak_run = r_peak_run;
        w_nxt_peak     = r_peak;
        w_nxt_onset    = 1'b0;
        w_nxt_pv       = 1'b0;
        w_nxt_evt      = r_evt;
        w_enter_alarm  = 1'b0;

        if (w_proc) begin
            case (r_state)
                S_IDLE: begin
                    if (w_above) begin
                        w_nxt_cnt      = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        w_nxt_peak_run = din;
                        if (w_on_eff <= {{CNT_WIDTH{1'b0}}, 1'b1}) begin
                            w_enter_alarm = 1'b1;
                        end else begin
                            w_nxt_state = S_CAND;
                        end
                    end
                end
                S_CAND: begin
                    if (w_above) begin
                        w_nxt_cnt      = w_cnt_inc[CNT_WIDTH-1:0];
                        w_nxt_peak_run = w_peak_max;
                        if (w_cnt_inc >= w_on_eff) begin
                            w_enter_alarm = 1'b1;
                        end
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_cnt   = '0;
                    end
                end
                S_ALARM: begin
                    w_nxt_peak_run = w_peak_max;
                    if (w_below) begin
                        if (w_cnt_inc >= w_off_eff) begin
                            w_nxt_state = S_HOLD;
                            w_nxt_cnt   = '0;
                            w_nxt_hcnt  = '0;
                            w_nxt_peak  = w_peak_max;
                            w_nxt_pv    = 1'b1;
                        end else begin
                            w_nxt_cnt = w_cnt_inc[CNT_WIDTH-1:0];
                        end
                    end else begin
                        w_nxt_cnt = '0;
                    end
                end
                S_HOLD: begin
                    if (w_hcnt_inc >= {1'b0, n_hold}) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_hcnt  = '0;
                    end else begin
                        w_nxt_hcnt = w_hcnt_inc[HOLD_WIDTH-1:0];
                    end
                end
                default: w_nxt_state = S_IDLE;
            endcase
        end

        if (w_enter_alarm) begin
            w_nxt_state = S_ALARM;
            w_nxt_cnt   = '0;
            w_nxt_onset = 1'b1;
            w_nxt_evt   = (&r_evt) ? r_evt : r_evt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_peak_run <= '0;
            r_peak     <= '0;
            r_onset    <= 1'b0;
            r_pv       <= 1'b0;
            r_evt      <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_hcnt     <= w_nxt_hcnt;
            r_peak_run <= w_nxt_peak_run;
            r_peak     <= w_nxt_peak;
            r_onset    <= w_nxt_onset;
            r_pv       <= w_nxt_pv;
            r_evt      <= w_nxt_evt;
        end
    end

    assign alarm       = (r_state == S_ALARM);
    assign onset_pulse = r_onset;
    assign peak        = r_peak;
    assign peak_valid  = r_pv;
    assign event_count = r_evt;
    assign state_dbg   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_ll_event_detector.sv
// ============================================================================
// Module  : tb_ll_event_detector
// Brief   : Table vectors, corner sequences and randomized run for ll_event_detector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ll_event_detector;

    logic               clk;
    logic               rst;
    logic               en;
    logic signed [24:0] din;
    logic               din_valid;
    logic signed [24:0] thr_hi;
    logic signed [24:0] thr_lo;
    logic [7:0]         n_onset;
    logic [7:0]         n_offset;
    logic [9:0]         n_hold;

    logic               alarm, onset_pulse, peak_valid;
    logic [24:0]        peak;
    logic [15:0]        event_count;
    logic [1:0]         state_dbg;

    logic               s_alarm, s_onset_pulse, s_peak_valid;
    logic [24:0]        s_peak;
    logic [1:0]         s_event_count;
    logic [1:0]         s_state_dbg;

    int checks = 0;
    int errors = 0;

    ll_event_detector u_dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .n_onset(n_onset), .n_offset(n_offset),
        .n_hold(n_hold), .alarm(alarm), .onset_pulse(onset_pulse), .peak(peak),
        .peak_valid(peak_valid), .event_count(event_count), .state_dbg(state_dbg)
    );

    ll_event_detector #(.EVT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .n_onset(n_onset), .n_offset(n_offset),
        .n_hold(n_hold), .alarm(s_alarm), .onset_pulse(s_onset_pulse), .peak(s_peak),
        .peak_valid(s_peak_valid), .event_count(s_event_count), .state_dbg(s_state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: episode samples kept in a queue, peak is the queue max.
    localparam int PH_IDLE = 0, PH_CAND = 1, PH_ALARM = 2, PH_HOLD = 3;
    int m_phase, m_run, m_held, m_evt, m_peak;
    bit m_onset, m_pv;
    int m_ep[$];

    task automatic model_reset();
        m_phase = PH_IDLE; m_run = 0; m_held = 0; m_evt = 0; m_peak = 0;
        m_onset = 0; m_pv = 0; m_ep.delete();
    endtask

    task automatic model_enter_alarm();
        m_phase = PH_ALARM; m_onset = 1; m_evt++; m_run = 0;
    endtask

    task automatic model_step(bit p, int d);
        int thi  = int'(thr_hi);
        int tlo  = int'(thr_lo);
        int eon  = (n_onset == 0) ? 1 : int'(n_onset);
        int eoff = (n_offset == 0) ? 1 : int'(n_offset);
        int mx;
        m_onset = 0;
        m_pv    = 0;
        if (!p) return;
        case (m_phase)
            PH_IDLE: if (d > thi) begin
                m_ep.delete(); m_ep.push_back(d); m_run = 1;
                if (m_run >= eon) model_enter_alarm(); else m_phase = PH_CAND;
            end
            PH_CAND: if (d > thi) begin
                m_ep.push_back(d); m_run++;
                if (m_run >= eon) model_enter_alarm();
            end else begin
                m_phase = PH_IDLE; m_run = 0;
            end
            PH_ALARM: begin
                m_ep.push_back(d);
                if (d < tlo) begin
                    m_run++;
                    if (m_run >= eoff) begin
                        mx = m_ep[0];
                        foreach (m_ep[k]) if (m_ep[k] > mx) mx = m_ep[k];
                        m_peak = mx; m_pv = 1; m_phase = PH_HOLD; m_held = 0; m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            default: begin
                m_held++;
                if (m_held >= int'(n_hold)) m_phase = PH_IDLE;
            end
        endcase
    endtask

    task automatic compare_model(string tag);
        chk({tag, "_alarm"}, int'(alarm), int'(m_phase == PH_ALARM));
        chk({tag, "_onset"}, int'(onset_pulse), int'(m_onset));
        chk({tag, "_pv"}, int'(peak_valid), int'(m_pv));
        chk({tag, "_state"}, int'(state_dbg), m_phase);
        chk({tag, "_peak"}, int'($signed(peak)), m_peak);
        chk({tag, "_evt"}, int'(event_count), (m_evt > 65535) ? 65535 : m_evt);
        chk({tag, "_satevt"}, int'(s_event_count), (m_evt > 3) ? 3 : m_evt);
    endtask

    task automatic step(int d, bit v, bit e, string tag);
        din = d; din_valid = v; en = e;
        @(posedge clk);
        #1;
        model_step(v && !e, d);
        compare_model(tag);
    endtask

    typedef struct {
        int din; bit valid; bit enb; int tlo;
        bit alarm; bit onset; bit pv; int state; int evt; int peak;
    } vec_t;
    vec_t tbl[$];

    initial begin
        rst = 1'b1; en = 1'b0; din = '0; din_valid = 1'b0;
        thr_hi = 25'sd1000; thr_lo = 25'sd500;
        n_onset = 8'd3; n_offset = 8'd2; n_hold = 10'd4;
        model_reset();

        tbl.push_back('{100,  1, 0, 500, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{100,  1, 0, 500, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{100,  1, 0, 500, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1500, 1, 0, 500, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{1600, 1, 0, 500, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{900,  1, 0, 500, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1500, 1, 0, 500, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{1500, 1, 0, 500, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{1700, 1, 0, 500, 1, 1, 0, 2, 1, 0});
        tbl.push_back('{2500, 1, 0, 500, 1, 0, 0, 2, 1, 0});
        tbl.push_back('{400,  1, 0, 500, 1, 0, 0, 2, 1, 0});
        tbl.push_back('{600,  1, 0, 500, 1, 0, 0, 2, 1, 0});
        tbl.push_back('{300,  1, 0, 500, 1, 0, 0, 2, 1, 0});
        tbl.push_back('{200,  1, 0, 500, 0, 0, 1, 3, 1, 2500});
        tbl.push_back('{5000, 1, 0, 500, 0, 0, 0, 3, 1, 2500});
        tbl.push_back('{5000, 1, 0, 500, 0, 0, 0, 3, 1, 2500});
        tbl.push_back('{5000, 1, 0, 500, 0, 0, 0, 3, 1, 2500});
        tbl.push_back('{5000, 1, 0, 500, 0, 0, 0, 0, 1, 2500});
        tbl.push_back('{5000, 1, 0, 500, 0, 0, 0, 1, 1, 2500});
        tbl.push_back('{5000, 1, 0, 500, 0, 0, 0, 1, 1, 2500});
        tbl.push_back('{5000, 1, 0, 500, 1, 1, 0, 2, 2, 2500});
        tbl.push_back('{9999, 1, 1, 500, 1, 0, 0, 2, 2, 2500});
        tbl.push_back('{9999, 0, 0, 500, 1, 0, 0, 2, 2, 2500});
        tbl.push_back('{-5,   1, 0, 0,   1, 0, 0, 2, 2, 2500});
        tbl.push_back('{-5,   1, 0, 0,   0, 0, 1, 3, 2, 5000});

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        compare_model("rst");

        foreach (tbl[i]) begin
            thr_lo = tbl[i].tlo;
            step(tbl[i].din, tbl[i].valid, tbl[i].enb, $sformatf("m%0d", i));
            chk($sformatf("t%0d_alarm", i), int'(alarm), int'(tbl[i].alarm));
            chk($sformatf("t%0d_onset", i), int'(onset_pulse), int'(tbl[i].onset));
            chk($sformatf("t%0d_pv", i), int'(peak_valid), int'(tbl[i].pv));
            chk($sformatf("t%0d_state", i), int'(state_dbg), tbl[i].state);
            chk($sformatf("t%0d_evt", i), int'(event_count), tbl[i].evt);
            chk($sformatf("t%0d_peak", i), int'($signed(peak)), tbl[i].peak);
        end

        // Asynchronous reset in the middle of an alarm.
        thr_lo = 25'sd500;
        repeat (4) step(0, 1, 0, "hx");
        repeat (3) step(2000, 1, 0, "ra");
        chk("pre_rst_alarm", int'(alarm), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_alarm", int'(alarm), 0);
        chk("arst_state", int'(state_dbg), 0);
        chk("arst_evt", int'(event_count), 0);
        chk("arst_peak", int'(peak), 0);
        model_reset();
        din = 25'sd100; din_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("arst_pv", int'(peak_valid), 0);
        end
        rst = 1'b0;

        // Zero counts: single-sample onset/offset, hold exits on first sample.
        n_onset = 8'd0; n_offset = 8'd0; n_hold = 10'd0;
        for (int e = 0; e < 5; e++) begin
            step(2000, 1, 0, "sa");
            step(100, 1, 0, "sb");
            step(100, 1, 0, "sc");
        end
        chk("sat_evt_final", int'(s_event_count), 3);
        chk("main_evt_final", int'(event_count), 5);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(19) == 0) begin
                thr_hi   = 25'($urandom_range(2000));
                thr_lo   = thr_hi - 25'($urandom_range(1500));
                n_onset  = 8'($urandom_range(4));
                n_offset = 8'($urandom_range(4));
                n_hold   = 10'($urandom_range(5));
            end
            step(int'($urandom_range(4000)) - 1000, $urandom_range(9) < 8,
                 $urandom_range(9) == 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
